// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - scan-code-set-2 constants, decode states and ASCII map
package ps2_kbd_pkg;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_SPACE  = 8'h29;
   localparam logic [7:0] SC_ENTER  = 8'h5A;
   localparam logic [7:0] SC_BKSP   = 8'h66;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BRK,
      ST_EXT,
      ST_EXT_BRK
   } dec_state_t;

   // Returns {hit, ascii}; letters derive their upper case from the lower case entry.
   function automatic logic [8:0] scan2ascii(input logic [7:0] code, input logic shift);
      logic [7:0] lo;
      logic [7:0] up;
      logic       hit;
      lo  = 8'h00;
      up  = 8'h00;
      hit = 1'b1;
      case (code)
         8'h1C: lo = 8'h61;
         8'h32: lo = 8'h62;
         8'h21: lo = 8'h63;
         8'h23: lo = 8'h64;
         8'h24: lo = 8'h65;
         8'h2B: lo = 8'h66;
         8'h34: lo = 8'h67;
         8'h33: lo = 8'h68;
         8'h43: lo = 8'h69;
         8'h3B: lo = 8'h6A;
         8'h42: lo = 8'h6B;
         8'h4B: lo = 8'h6C;
         8'h3A: lo = 8'h6D;
         8'h31: lo = 8'h6E;
         8'h44: lo = 8'h6F;
         8'h4D: lo = 8'h70;
         8'h15: lo = 8'h71;
         8'h2D: lo = 8'h72;
         8'h1B: lo = 8'h73;
         8'h2C: lo = 8'h74;
         8'h3C: lo = 8'h75;
         8'h2A: lo = 8'h76;
         8'h1D: lo = 8'h77;
         8'h22: lo = 8'h78;
         8'h35: lo = 8'h79;
         8'h1A: lo = 8'h7A;
         8'h16: begin lo = 8'h31; up = 8'h21; end
         8'h1E: begin lo = 8'h32; up = 8'h40; end
         8'h26: begin lo = 8'h33; up = 8'h23; end
         8'h25: begin lo = 8'h34; up = 8'h24; end
         8'h2E: begin lo = 8'h35; up = 8'h25; end
         8'h36: begin lo = 8'h36; up = 8'h5E; end
         8'h3D: begin lo = 8'h37; up = 8'h26; end
         8'h3E: begin lo = 8'h38; up = 8'h2A; end
         8'h46: begin lo = 8'h39; up = 8'h28; end
         8'h45: begin lo = 8'h30; up = 8'h29; end
         SC_SPACE: begin lo = 8'h20; up = 8'h20; end
         SC_ENTER: begin lo = 8'h0D; up = 8'h0D; end
         SC_BKSP:  begin lo = 8'h08; up = 8'h08; end
         default: hit = 1'b0;
      endcase
      if (lo >= 8'h61 && lo <= 8'h7A) begin
         up = lo - 8'h20;
      end
      return {hit, (shift ? up : lo)};
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 device-to-host frame deserialiser with parity, stop and timeout checks
module ps2_frame_rx #(
   parameter int TIMEOUT_CYCLES = 25000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]    r_clk_sync;
   logic [1:0]    r_dat_sync;
   logic          r_clk_prev;
   logic [3:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic          r_parity;
   logic [7:0]    r_byte;
   logic          r_byte_valid;
   logic          r_frame_err;
   logic [TW-1:0] r_idle;
   logic          w_fall;
   logic          w_dat;

   assign w_fall = r_clk_prev & ~r_clk_sync[1];
   assign w_dat  = r_dat_sync[1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_clk_sync   <= 2'b11;
         r_dat_sync   <= 2'b11;
         r_clk_prev   <= 1'b1;
         r_bit_cnt    <= 4'd0;
         r_shift      <= 8'h00;
         r_parity     <= 1'b0;
         r_byte       <= 8'h00;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_idle       <= '0;
      end else begin
         r_clk_sync   <= {r_clk_sync[0], i_ps2_clk};
         r_dat_sync   <= {r_dat_sync[0], i_ps2_data};
         r_clk_prev   <= r_clk_sync[1];
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         if (w_fall) begin
            r_idle <= '0;
            if (r_bit_cnt == 4'd0) begin
               // A high start bit is line noise: drop it and keep hunting.
               if (w_dat) begin
                  r_frame_err <= 1'b1;
               end else begin
                  r_bit_cnt <= 4'd1;
               end
            end else if (r_bit_cnt <= 4'd8) begin
               r_shift   <= {w_dat, r_shift[7:1]};
               r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (r_bit_cnt == 4'd9) begin
               r_parity  <= w_dat;
               r_bit_cnt <= 4'd10;
            end else begin
               r_bit_cnt <= 4'd0;
               if (w_dat && (^{r_shift, r_parity})) begin
                  r_byte       <= r_shift;
                  r_byte_valid <= 1'b1;
               end else begin
                  r_frame_err <= 1'b1;
               end
            end
         end else if (r_bit_cnt != 4'd0) begin
            if (r_idle == TW'(TIMEOUT_CYCLES - 1)) begin
               r_bit_cnt   <= 4'd0;
               r_idle      <= '0;
               r_frame_err <= 1'b1;
            end else begin
               r_idle <= r_idle + TW'(1);
            end
         end else begin
            r_idle <= '0;
         end
      end
   end

   assign o_byte       = r_byte;
   assign o_byte_valid = r_byte_valid;
   assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// rtl/ps2_keyboard_decoder.sv - PS/2 keyboard to ASCII decoder with output FIFO
module ps2_keyboard_decoder
   import ps2_kbd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 25000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       clk_25mhz,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] char_data,
   output logic       char_valid,
   input  logic       char_ready,
   output logic       frame_err,
   output logic       overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [7:0]  w_rx_byte;
   logic        w_rx_valid;
   logic        w_rx_err;
   logic [8:0]  w_map;

   dec_state_t  r_state;
   dec_state_t  w_state_nxt;
   logic        r_lshift;
   logic        r_rshift;
   logic        w_lshift_nxt;
   logic        w_rshift_nxt;
   logic        w_emit;
   logic        r_wr_en;
   logic [7:0]  r_wr_data;

   logic [7:0]  r_mem [FIFO_DEPTH];
   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic        r_overflow;
   logic        w_empty;
   logic        w_full;
   logic        w_pop;
   logic        w_push;

   ps2_frame_rx #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .i_clk       (clk_25mhz),
      .i_rst_n     (reset),
      .i_ps2_clk   (ps2_clk),
      .i_ps2_data  (ps2_data),
      .o_byte      (w_rx_byte),
      .o_byte_valid(w_rx_valid),
      .o_frame_err (w_rx_err)
   );

   assign w_map = scan2ascii(w_rx_byte, r_lshift | r_rshift);

   always_ff @(posedge clk_25mhz or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_lshift  <= 1'b0;
         r_rshift  <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_data <= 8'h00;
      end else begin
         r_state   <= w_state_nxt;
         r_lshift  <= w_lshift_nxt;
         r_rshift  <= w_rshift_nxt;
         r_wr_en   <= w_emit;
         r_wr_data <= w_map[7:0];
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_lshift_nxt = r_lshift;
      w_rshift_nxt = r_rshift;
      w_emit       = 1'b0;
      // A corrupted byte may have been a prefix, so never trust the pending state.
      if (w_rx_err) begin
         w_state_nxt = ST_IDLE;
      end else if (w_rx_valid) begin
         case (r_state)
            ST_IDLE: begin
               if (w_rx_byte == SC_BREAK) begin
                  w_state_nxt = ST_BRK;
               end else if (w_rx_byte == SC_EXT) begin
                  w_state_nxt = ST_EXT;
               end else if (w_rx_byte == SC_LSHIFT) begin
                  w_lshift_nxt = 1'b1;
               end else if (w_rx_byte == SC_RSHIFT) begin
                  w_rshift_nxt = 1'b1;
               end else begin
                  w_emit = w_map[8];
               end
            end
            ST_BRK: begin
               if (w_rx_byte == SC_LSHIFT) begin
                  w_lshift_nxt = 1'b0;
               end else if (w_rx_byte == SC_RSHIFT) begin
                  w_rshift_nxt = 1'b0;
               end
               w_state_nxt = ST_IDLE;
            end
            ST_EXT: begin
               w_state_nxt = (w_rx_byte == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_pop   = ~w_empty & char_ready;
   // When full, a same-cycle pop frees the slot the push lands in.
   assign w_push  = r_wr_en & (~w_full | w_pop);

   always_ff @(posedge clk_25mhz or negedge reset) begin
      if (!reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_ONE;
         end
         r_overflow <= r_wr_en & w_full & ~w_pop;
      end
   end

   always_ff @(posedge clk_25mhz) begin
      if (w_push) begin
         r_mem[r_wptr[AW-1:0]] <= r_wr_data;
      end
   end

   assign char_valid = ~w_empty;
   assign char_data  = w_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];
   assign frame_err  = w_rx_err;
   assign overflow   = r_overflow;

endmodule
